video_scale_packer: RTL



---
 rtl/video_scale_packer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/video_scale_packer.sv
// Horizontal/vertical step/256 decimator that pads/truncates each kept line to OUT_WIDTH,
// packs pixels into DDR words and queues them in a single-clock FIFO for the write arbiter.
module video_scale_packer #(
  parameter int unsigned          PIX_WIDTH   = 16,
  parameter int unsigned          DQ_WIDTH    = 32,
  parameter int unsigned          VIDEO_WIDTH = 1280,
  parameter int unsigned          OUT_WIDTH   = 960,
  parameter int unsigned          FIFO_DEPTH  = 64,
  parameter int unsigned          BURST_WORDS = 16,
  parameter logic [3:0]           IMAGE_TAG   = 4'd1,
  parameter logic [PIX_WIDTH-1:0] PAD_VALUE   = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          de_in,
  input  logic                          vs_in,
  input  logic [PIX_WIDTH-1:0]          pix_in,
  input  logic [8:0]                    h_step,
  input  logic [8:0]                    v_step,
  input  logic                          rd_en,
  output logic [DQ_WIDTH*8-1:0]         rd_data,
  output logic                          data_out_ready,
  output logic [3:0]                    trans_id,
  output logic                          burst_emergency,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  output logic                          line_err
);
  localparam int unsigned DW   = DQ_WIDTH * 8;
  localparam int unsigned PPW  = DW / PIX_WIDTH;
  localparam int unsigned PW   = $clog2(PPW);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned MAXW = (VIDEO_WIDTH > OUT_WIDTH) ? VIDEO_WIDTH : OUT_WIDTH;
  localparam int unsigned CW   = $clog2(MAXW + 1);

  localparam logic [CW-1:0] OUT_W     = CW'(OUT_WIDTH);
  localparam logic [PW-1:0] LAST_SLOT = PW'(PPW - 1);
  localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   BURST_L   = (AW + 1)'(BURST_WORDS);

  typedef enum logic [1:0] {StIdle, StLine, StPad} state_e;

  state_e                            state_q, state_d;
  logic                              vs_q, de_q;
  logic                              frame_start, de_rise, de_fall;
  logic [8:0]                        hstep_q, vstep_q, hacc_q, vacc_q;
  logic [8:0]                        h_eff, v_eff, ha, va;
  logic                              h_keep, v_keep, line_go, pad_go, pad_cut;
  logic [CW-1:0]                     col_q;
  logic                              p0_valid_q, s1_valid_q, word_valid_q;
  logic [PIX_WIDTH-1:0]              p0_pix_q, s1_pix_q;
  logic [PW-1:0]                     pk_cnt_q;
  logic [PPW-1:0][PIX_WIDTH-1:0]     pk_word_q, pk_next;
  logic [DW-1:0]                     word_q;
  logic [DW-1:0]                     mem_q [FIFO_DEPTH];
  logic [AW-1:0]                     wptr_q, rptr_q;
  logic [AW:0]                       count_q;
  logic                              full, push_ok, pop;

  assign frame_start = vs_in & ~vs_q;
  assign de_rise     = de_in & ~de_q;
  assign de_fall     = ~de_in & de_q;

  // A latched step of 0 means keep everything (256/256).
  assign h_eff  = (hstep_q == 9'd0) ? 9'd256 : hstep_q;
  assign v_eff  = (vstep_q == 9'd0) ? 9'd256 : vstep_q;
  assign ha     = hacc_q + h_eff;
  assign va     = vacc_q + v_eff;
  assign h_keep = ha[8];
  assign v_keep = va[8];

  assign line_go = (state_q == StLine) | (de_rise & v_keep);
  assign pad_go  = (state_q == StPad) & ~de_rise & (col_q < OUT_W);
  assign pad_cut = (state_q == StPad) & de_rise & (col_q != OUT_W);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (de_rise && v_keep) state_d = StLine;
      StLine: if (de_fall) state_d = StPad;
      StPad: begin
        if (de_rise)             state_d = v_keep ? StLine : StIdle;
        else if (col_q == OUT_W) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pk_next           = pk_word_q;
    pk_next[pk_cnt_q] = s1_pix_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      hstep_q <= '0;
      vstep_q <= '0;
    end else begin
      vs_q    <= vs_in;
      de_q    <= de_in;
      state_q <= frame_start ? StIdle : state_d;
      if (frame_start) begin
        hstep_q <= h_step;
        vstep_q <= v_step;
      end
    end
  end

  // Stage p0 samples the pixel, s1 holds the keep decision, the packer consumes s1.
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      p0_valid_q   <= 1'b0;
      s1_valid_q   <= 1'b0;
      word_valid_q <= 1'b0;
      pk_cnt_q     <= '0;
      hacc_q       <= '0;
      vacc_q       <= '0;
      col_q        <= '0;
    end else begin
      p0_valid_q <= de_in & line_go;
      if (de_rise) begin
        hacc_q     <= '0;
        col_q      <= '0;
        s1_valid_q <= 1'b0;
        vacc_q     <= v_keep ? {1'b0, va[7:0]} : va;
      end else if (p0_valid_q) begin
        hacc_q     <= h_keep ? {1'b0, ha[7:0]} : ha;
        s1_valid_q <= h_keep && (col_q < OUT_W);
        if (h_keep && (col_q < OUT_W)) col_q <= col_q + CW'(1);
      end else if (pad_go) begin
        s1_valid_q <= 1'b1;
        col_q      <= col_q + CW'(1);
      end else begin
        s1_valid_q <= 1'b0;
      end

      if (pad_cut) begin
        pk_cnt_q     <= '0;
        word_valid_q <= 1'b0;
      end else if (s1_valid_q) begin
        word_valid_q <= (pk_cnt_q == LAST_SLOT);
        pk_cnt_q     <= (pk_cnt_q == LAST_SLOT) ? '0 : pk_cnt_q + PW'(1);
      end else begin
        word_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    p0_pix_q <= pix_in;
    s1_pix_q <= p0_valid_q ? p0_pix_q : PAD_VALUE;
    if (s1_valid_q) pk_word_q <= pk_next;
    if (s1_valid_q && pk_cnt_q == LAST_SLOT) word_q <= pk_next;
    if (push_ok) mem_q[wptr_q] <= word_q;
  end

  assign full       = (count_q == DEPTH_L);
  assign push_ok    = word_valid_q & ~full;
  assign pop        = rd_en & (count_q != '0);
  assign fill_level = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      rd_data         <= '0;
      overflow        <= 1'b0;
      line_err        <= 1'b0;
      data_out_ready  <= 1'b0;
      trans_id        <= '0;
      burst_emergency <= 1'b0;
    end else begin
      data_out_ready  <= (count_q >= BURST_L);
      trans_id        <= (count_q >= BURST_L) ? IMAGE_TAG : 4'd0;
      burst_emergency <= full;
      if (frame_start) begin
        wptr_q   <= '0;
        rptr_q   <= '0;
        count_q  <= '0;
        overflow <= 1'b0;
        line_err <= 1'b0;
      end else begin
        if (push_ok) wptr_q <= wptr_q + AW'(1);
        if (pop) begin
          rptr_q  <= rptr_q + AW'(1);
          rd_data <= mem_q[rptr_q];
        end
        count_q <= count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
        if (word_valid_q && full) overflow <= 1'b1;
        if (pad_cut) line_err <= 1'b1;
      end
    end
  end

endmodule
